mc_main_ctrl: RTL and testbench
===============================

Name: mc_main_ctrl

Overview:
- Main control state machine for the multicycle processor datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 2-bit select lines of the datapath's 4-input operand and PC multiplexers (alusrcb, pcsrc), plus every datapath enable and strobe.
- Sits directly upstream of those muxes. Adds a memory-ready handshake so fetch and data accesses can stall.

Parameters:
- OPW, 6, opcode field width.
- STW, 4, width of the state register and debug state output.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- op  in  OPW  opcode of the instruction register.
- mem_ready  in  1  memory completes the current access this cycle.
- alusrca  out  1  ALU A select: 0=PC, 1=register A.
- alusrcb  out  2  ALU B mux select: 00=B, 01=const 4, 10=SignImm, 11=SignImm<<2.
- aluop  out  2  to ALU decoder: 00=add, 01=sub, 10=funct.
- pcsrc  out  2  PC mux select: 00=ALUResult, 01=ALUOut, 10=jump target.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- memtoreg  out  1  writeback data select.
- regdst  out  1  writeback register select: 1=rd, 0=rt.
- irwrite  out  1  instruction register load.
- pcwrite  out  1  unconditional PC load.
- branch  out  1  conditional PC load; datapath ANDs it with zero.
- memwrite  out  1  data memory write strobe.
- regwrite  out  1  register file write strobe.
- illegal_op  out  1  one-cycle pulse for an unsupported opcode.
- state  out  STW  current state, for debug.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Outputs are Moore functions of the state register, except where gating by mem_ready is stated below.
- Any output not listed for a state is 0.

Reset:
- While rst_n=0, state=FETCH(0), irwrite, pcwrite, memwrite, regwrite and illegal_op are all 0.
- Other outputs take their FETCH values: alusrcb=01, others 0.
- Reset asserted mid-instruction abandons that instruction immediately. No write strobe may glitch high.

States and encodings:
- FETCH(0): alusrcb=01, irwrite=mem_ready, pcwrite=mem_ready. Stays in FETCH while mem_ready=0. Goes to DECODE when mem_ready=1.
- DECODE(1): alusrcb=11.
  - Next state by op: 100011 (lw) and 101011 (sw) -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEXEC; 000010 -> JUMP.
  - Any other op -> FETCH, with illegal_op=1 for this cycle only.
- MEMADR(2): alusrca=1, alusrcb=10. lw -> MEMRD; sw -> MEMWR. Uses the op captured at DECODE, not the live input.
- MEMRD(3): iord=1. Holds until mem_ready=1, then -> MEMWB.
- MEMWB(4): memtoreg=1, regwrite=1 -> FETCH.
- MEMWR(5): iord=1, memwrite=1 every cycle while waiting. Holds until mem_ready=1, then -> FETCH.
- EXECUTE(6): alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
- ALUWB(7): regdst=1, regwrite=1 -> FETCH.
- BRANCH(8): alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 -> FETCH.
- ADDIEXEC(9): alusrca=1, alusrcb=10 -> ADDIWB.
- ADDIWB(10): regwrite=1 -> FETCH.
- JUMP(11): pcsrc=10, pcwrite=1 -> FETCH.
- Encodings 12–15 are unreachable. If entered, the FSM returns to FETCH next cycle with all strobes 0.

Opcode capture:
- op is registered internally on the DECODE cycle.
- Later states use that registered copy, so op may change after DECODE without effect.

Latency with mem_ready held at 1:
- R-type 4 cycles; lw 5; sw 4; beq 3; addi 4; j 3.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.

Simultaneous events:
- Reset deassertion coincident with mem_ready=1: the first rising edge after release samples mem_ready and may advance FETCH->DECODE.

Test Plan:
1. Reset sequence: pulse rst_n=0 mid-EXECUTE -> state=0 immediately, asynchronously. During reset regwrite=pcwrite=irwrite=0 and alusrcb=01. After release with mem_ready=1, DECODE is reached on the next edge.
2. R-type, op=000000, mem_ready=1 -> states 0,1,6,7,0. alusrcb sequence 01,11,00,00. aluop=10 in EXECUTE; regwrite=1 and regdst=1 only in ALUWB.
3. lw with stalls: op=100011, mem_ready low 2 cycles in FETCH and 3 cycles in MEMRD -> 10 cycles total. irwrite/pcwrite high only on the FETCH exit cycle; iord=1 for all 4 MEMRD cycles; memtoreg=1 and regwrite=1 in MEMWB.
4. sw then beq: sw drives memwrite=1 for every MEMWR cycle until mem_ready, then returns to FETCH. beq (000100) shows pcsrc=01, aluop=01, branch=1 in state 8, and 3 cycles total.
5. Jump and addi: j (000010) gives pcsrc=10, pcwrite=1 in state 11. addi (001000) gives alusrcb=10 in ADDIEXEC, then regwrite=1 with regdst=0.
6. Illegal opcode and op change: op=111111 gives illegal_op=1 for exactly 1 cycle in DECODE, then FETCH, with no write strobes. Changing op from 100011 to 101011 during MEMADR still goes to MEMRD.

Source files
------------

// File: rtl/mc_main_ctrl_if.sv
// Control bundle between the multicycle main controller and the datapath:
// opcode and memory-ready toward the controller, mux selects, strobes and debug state back out.
interface mc_main_ctrl_if #(
    parameter int OPW = 6,
    parameter int STW = 4
);
    logic [OPW-1:0] op;
    logic           mem_ready;
    logic           alusrca;
    logic [1:0]     alusrcb;
    logic [1:0]     aluop;
    logic [1:0]     pcsrc;
    logic           iord;
    logic           memtoreg;
    logic           regdst;
    logic           irwrite;
    logic           pcwrite;
    logic           branch;
    logic           memwrite;
    logic           regwrite;
    logic           illegal_op;
    logic [STW-1:0] state;

    modport master (
        input  op, mem_ready,
        output alusrca, alusrcb, aluop, pcsrc, iord, memtoreg, regdst,
               irwrite, pcwrite, branch, memwrite, regwrite, illegal_op, state
    );

    modport slave (
        output op, mem_ready,
        input  alusrca, alusrcb, aluop, pcsrc, iord, memtoreg, regdst,
               irwrite, pcwrite, branch, memwrite, regwrite, illegal_op, state
    );
endinterface

// File: rtl/mc_main_ctrl.sv
// Main control FSM for the multicycle datapath: fetch/decode/execute/memory/writeback
// sequencing with mem_ready stalls in FETCH, MEMRD and MEMWR.
module mc_main_ctrl #(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_main_ctrl_if.master bus
);

    typedef enum logic [STW-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;

    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       iord, memtoreg, regdst, irwrite, pcwrite;
    logic       branch, memwrite, regwrite, illegal_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        pcsrc      = 2'b00;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                // FETCH strobes follow mem_ready combinationally; rst_n keeps them low while held in reset
                irwrite = bus.mem_ready & rst_n;
                pcwrite = bus.mem_ready & rst_n;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                op_d    = bus.op;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.aluop      = aluop;
    assign bus.pcsrc      = pcsrc;
    assign bus.iord       = iord;
    assign bus.memtoreg   = memtoreg;
    assign bus.regdst     = regdst;
    assign bus.irwrite    = irwrite;
    assign bus.pcwrite    = pcwrite;
    assign bus.branch     = branch;
    assign bus.memwrite   = memwrite;
    assign bus.regwrite   = regwrite;
    assign bus.illegal_op = illegal_op;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Bench for mc_main_ctrl: directed instruction scenarios plus a randomized instruction
// stream checked against a per-instruction state-path model.
module tb_mc_main_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mc_main_ctrl_if #(.OPW(6), .STW(4)) bus ();

    mc_main_ctrl #(.OPW(6), .STW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [16:0] act_vec;
    assign act_vec = {bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsrc, bus.iord, bus.memtoreg,
                      bus.regdst, bus.irwrite, bus.pcwrite, bus.branch, bus.memwrite,
                      bus.regwrite, bus.illegal_op};

    function automatic logic is_legal(input logic [5:0] o);
        return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // Expected outputs for a given state, straight from the per-state output table.
    function automatic logic [16:0] exp_vec(input int st, input logic mr, input logic [5:0] o);
        logic a, io, mt, rd, ir, pw, br, mw, rw, il;
        logic [1:0] b, alu, pc;
        {a, io, mt, rd, ir, pw, br, mw, rw, il} = '0;
        b = 2'b00; alu = 2'b00; pc = 2'b00;
        case (st)
            0:  begin b = 2'b01; ir = mr; pw = mr; end
            1:  begin b = 2'b11; il = !is_legal(o); end
            2:  begin a = 1'b1; b = 2'b10; end
            3:  io = 1'b1;
            4:  begin mt = 1'b1; rw = 1'b1; end
            5:  begin io = 1'b1; mw = 1'b1; end
            6:  begin a = 1'b1; alu = 2'b10; end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin a = 1'b1; alu = 2'b01; pc = 2'b01; br = 1'b1; end
            9:  begin a = 1'b1; b = 2'b10; end
            10: rw = 1'b1;
            11: begin pc = 2'b10; pw = 1'b1; end
            default: ;
        endcase
        return {a, b, alu, pc, io, mt, rd, ir, pw, br, mw, rw, il};
    endfunction

    task automatic drive(input logic [5:0] o, input logic mr);
        @(negedge clk);
        bus.op        = o;
        bus.mem_ready = mr;
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.op        = '0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        drive(6'b000000, 1'b1);
        drive(6'b000000, 1'b1);
        drive(6'b000000, 1'b1);
        checks++;
        if (bus.state !== 4'd6) begin
            errors++; $display("FAIL reset_pre_exec: state got %0d exp 6", bus.state);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.state !== 4'd0) begin
            errors++; $display("FAIL reset_async_state: state got %0d exp 0", bus.state);
        end
        checks++;
        if ({bus.regwrite, bus.pcwrite, bus.irwrite, bus.memwrite, bus.illegal_op} !== 5'b0 ||
            bus.alusrcb !== 2'b01) begin
            errors++; $display("FAIL reset_outputs: strobes %b alusrcb %b exp 00000 01",
                {bus.regwrite, bus.pcwrite, bus.irwrite, bus.memwrite, bus.illegal_op}, bus.alusrcb);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.state !== 4'd0 || bus.irwrite !== 1'b0) begin
            errors++; $display("FAIL reset_held: state %0d irwrite %b exp 0 0", bus.state, bus.irwrite);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.state !== 4'd1) begin
            errors++; $display("FAIL reset_release_decode: state got %0d exp 1", bus.state);
        end
    endtask

    task automatic test_rtype();
        int st_s[5] = '{0, 1, 6, 7, 0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(6'b000000, 1'b1);
            checks++;
            if (bus.state !== 4'(st_s[i])) begin
                errors++; $display("FAIL rtype_state[%0d]: got %0d exp %0d", i, bus.state, st_s[i]);
            end
            checks++;
            if (act_vec !== exp_vec(st_s[i], 1'b1, 6'b000000)) begin
                errors++; $display("FAIL rtype_outputs[%0d]: got %h exp %h", i, act_vec,
                    exp_vec(st_s[i], 1'b1, 6'b000000));
            end
        end
    endtask

    task automatic test_lw_stall();
        int   st_s[10] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
        logic mr_s[10] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
        logic [5:0] o;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            // op flips to sw during MEMADR; the captured lw must still steer to MEMRD
            o = (i <= 3) ? 6'b100011 : 6'b101011;
            drive(o, (i < 10) ? mr_s[i] : 1'b1);
            checks++;
            if (bus.state !== ((i < 10) ? 4'(st_s[i]) : 4'd0)) begin
                errors++; $display("FAIL lw_state[%0d]: got %0d exp %0d", i, bus.state,
                    (i < 10) ? st_s[i] : 0);
            end
            if (i < 10) begin
                checks++;
                if (act_vec !== exp_vec(st_s[i], mr_s[i], o)) begin
                    errors++; $display("FAIL lw_outputs[%0d]: got %h exp %h", i, act_vec,
                        exp_vec(st_s[i], mr_s[i], o));
                end
                checks++;
                if (bus.irwrite !== (i == 2) || bus.pcwrite !== (i == 2)) begin
                    errors++; $display("FAIL lw_fetch_strobe[%0d]: ir %b pc %b exp %b", i,
                        bus.irwrite, bus.pcwrite, (i == 2));
                end
            end
        end
    endtask

    task automatic test_sw_beq();
        int         st_s[10] = '{0, 1, 2, 5, 5, 5, 0, 1, 8, 0};
        logic       mr_s[10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
        logic [5:0] op_s[10] = '{6'b101011, 6'b101011, 6'b000000, 6'b100011, 6'b000000,
                                 6'b111111, 6'b000100, 6'b000100, 6'b000000, 6'b000000};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(op_s[i], mr_s[i]);
            checks++;
            if (bus.state !== 4'(st_s[i])) begin
                errors++; $display("FAIL swbeq_state[%0d]: got %0d exp %0d", i, bus.state, st_s[i]);
            end
            checks++;
            if (act_vec !== exp_vec(st_s[i], mr_s[i], op_s[i])) begin
                errors++; $display("FAIL swbeq_outputs[%0d]: got %h exp %h", i, act_vec,
                    exp_vec(st_s[i], mr_s[i], op_s[i]));
            end
            checks++;
            if (bus.memwrite !== (st_s[i] == 5)) begin
                errors++; $display("FAIL sw_memwrite[%0d]: got %b exp %b", i, bus.memwrite, (st_s[i] == 5));
            end
        end
    endtask

    task automatic test_jump_addi();
        int         st_s[8] = '{0, 1, 11, 0, 1, 9, 10, 0};
        logic [5:0] op_s[8] = '{6'b000010, 6'b000010, 6'b100011, 6'b001000, 6'b001000,
                                6'b000000, 6'b101011, 6'b000000};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(op_s[i], 1'b1);
            checks++;
            if (bus.state !== 4'(st_s[i])) begin
                errors++; $display("FAIL jaddi_state[%0d]: got %0d exp %0d", i, bus.state, st_s[i]);
            end
            checks++;
            if (act_vec !== exp_vec(st_s[i], 1'b1, op_s[i])) begin
                errors++; $display("FAIL jaddi_outputs[%0d]: got %h exp %h", i, act_vec,
                    exp_vec(st_s[i], 1'b1, op_s[i]));
            end
        end
    endtask

    task automatic test_illegal_op_change();
        int         st_s[8] = '{0, 1, 0, 1, 2, 3, 4, 0};
        logic [5:0] op_s[8] = '{6'b111111, 6'b111111, 6'b100011, 6'b100011, 6'b101011,
                                6'b101011, 6'b000000, 6'b000000};
        int ill_cnt = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(op_s[i], 1'b1);
            if (bus.illegal_op === 1'b1) ill_cnt++;
            checks++;
            if (bus.state !== 4'(st_s[i])) begin
                errors++; $display("FAIL illop_state[%0d]: got %0d exp %0d", i, bus.state, st_s[i]);
            end
            checks++;
            if (act_vec !== exp_vec(st_s[i], 1'b1, op_s[i])) begin
                errors++; $display("FAIL illop_outputs[%0d]: got %h exp %h", i, act_vec,
                    exp_vec(st_s[i], 1'b1, op_s[i]));
            end
        end
        checks++;
        if (ill_cnt != 1) begin
            errors++; $display("FAIL illop_pulse_count: got %0d exp 1", ill_cnt);
        end
    endtask

    // Random instruction stream: each instruction is a list of states after FETCH;
    // FETCH, MEMRD and MEMWR repeat while mem_ready is low.
    task automatic test_random();
        logic [5:0] legal[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        int         path[$];
        int         exp_st;
        logic [5:0] iop, o;
        logic       mr;
        int         k;
        do_reset();
        exp_st = 0;
        k = $urandom_range(0, 6);
        iop = (k < 6) ? legal[k] : 6'($urandom);
        path.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            mr = ($urandom_range(0, 3) != 0);
            o  = (exp_st == 1) ? iop : 6'($urandom);
            drive(o, mr);
            checks++;
            if (bus.state !== 4'(exp_st)) begin
                errors++; $display("FAIL rand_state[%0d]: got %0d exp %0d op %b", cyc, bus.state, exp_st, iop);
            end
            checks++;
            if (act_vec !== exp_vec(exp_st, mr, o)) begin
                errors++; $display("FAIL rand_outputs[%0d]: got %h exp %h st %0d", cyc, act_vec,
                    exp_vec(exp_st, mr, o), exp_st);
            end
            if (exp_st == 0 && path.size() == 0) begin
                case (iop)
                    6'b100011: path = '{1, 2, 3, 4};
                    6'b101011: path = '{1, 2, 5};
                    6'b000000: path = '{1, 6, 7};
                    6'b000100: path = '{1, 8};
                    6'b001000: path = '{1, 9, 10};
                    6'b000010: path = '{1, 11};
                    default:   path = '{1};
                endcase
            end
            if ((exp_st == 0 || exp_st == 3 || exp_st == 5) && !mr) begin
                exp_st = exp_st;
            end else if (path.size() != 0) begin
                exp_st = path.pop_front();
            end else begin
                exp_st = 0;
                k = $urandom_range(0, 6);
                iop = (k < 6) ? legal[k] : 6'($urandom);
            end
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.op        = '0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_sw_beq();
        test_jump_addi();
        test_illegal_op_change();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
